rb_block_fwd: RTL and testbench

- Parametrised successor to the 8-bit register bank with operand forwarding, sitting in the decode stage.
- Provides a DEPTH x DATA_W register file with two synchronous read ports and one write port.
- Forwarding selects are generated internally from the EX/DM/WB destination tags, instead of arriving as external mux selects.
- Adds a sequential clear-on-reset sweep, a decode-stage stall hold, and a write-first bypass.

---
 rtl/rb_pkg.sv | 17 +
 rtl/rb_block_fwd_if.sv | 44 ++++
 rtl/rb_fwd_sel.sv | 47 ++++
 rtl/rb_block_fwd.sv | 146 ++++++++++++++
 tb/tb_rb_block_fwd.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rb_pkg.sv
// Shared types for the rb_block_fwd register bank: forwarding-source select and
// the clear-sweep / run state.
package rb_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_EX = 2'b01,
        FWD_DM = 2'b10,
        FWD_WB = 2'b11
    } fwd_sel_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rb_state_t;

endpackage

// File: rtl/rb_block_fwd_if.sv
// Decode-stage register bank bus: read/write ports, pipeline forwarding tags,
// immediate select and the resolved operands.
interface rb_block_fwd_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              ready;
    logic              stall;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] ans_ex;
    logic [DATA_W-1:0] ans_dm;
    logic [DATA_W-1:0] ans_wb;
    logic [ADDR_W-1:0] rd_ex;
    logic [ADDR_W-1:0] rd_dm;
    logic [ADDR_W-1:0] rd_wb;
    logic              v_ex;
    logic              v_dm;
    logic              v_wb;
    logic [DATA_W-1:0] imm;
    logic              imm_sel;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [1:0]        fwd_sel_a;
    logic [1:0]        fwd_sel_b;

    modport master (
        input  ready, A, B, fwd_sel_a, fwd_sel_b,
        output stall, addr_a, addr_b, we, waddr, wdata,
               ans_ex, ans_dm, ans_wb, rd_ex, rd_dm, rd_wb,
               v_ex, v_dm, v_wb, imm, imm_sel
    );

    modport slave (
        output ready, A, B, fwd_sel_a, fwd_sel_b,
        input  stall, addr_a, addr_b, we, waddr, wdata,
               ans_ex, ans_dm, ans_wb, rd_ex, rd_dm, rd_wb,
               v_ex, v_dm, v_wb, imm, imm_sel
    );

endinterface

// File: rtl/rb_fwd_sel.sv
// Combinational operand forwarding mux, priority EX > DM > WB over the regfile.
// With RB_ZERO_REG_EN defined, register 0 is never forwarded.
module rb_fwd_sel
    import rb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] qaddr,
    input  logic              v_ex,
    input  logic              v_dm,
    input  logic              v_wb,
    input  logic [ADDR_W-1:0] rd_ex,
    input  logic [ADDR_W-1:0] rd_dm,
    input  logic [ADDR_W-1:0] rd_wb,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] ans_dm,
    input  logic [DATA_W-1:0] ans_wb,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] data,
    output fwd_sel_t          sel
);

    logic addr_ok;

`ifdef RB_ZERO_REG_EN
    assign addr_ok = (qaddr != '0);
`else
    assign addr_ok = 1'b1;
`endif

    always_comb begin
        data = rf_data;
        sel  = FWD_RF;
        if (addr_ok && v_ex && (rd_ex == qaddr)) begin
            data = ans_ex;
            sel  = FWD_EX;
        end else if (addr_ok && v_dm && (rd_dm == qaddr)) begin
            data = ans_dm;
            sel  = FWD_DM;
        end else if (addr_ok && v_wb && (rd_wb == qaddr)) begin
            data = ans_wb;
            sel  = FWD_WB;
        end
    end

endmodule

// File: rtl/rb_block_fwd.sv
// Decode-stage register bank with clear-on-reset sweep, stall hold, write-first
// bypass and internally generated forwarding. Optional macro: RB_ZERO_REG_EN.
module rb_block_fwd
    import rb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input logic          clk,
    input logic          rst_n,
    rb_block_fwd_if.slave bus
);

    rb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] ar_q, ar_d;
    logic [DATA_W-1:0] br_q, br_d;
    logic [ADDR_W-1:0] qa_q, qa_d;
    logic [ADDR_W-1:0] qb_q, qb_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_d;
    logic [DATA_W-1:0] mem_wdata_d;

    logic              wr_ok;
    logic              run;
    logic [DATA_W-1:0] data_a, data_b;
    fwd_sel_t          sel_a, sel_b;

`ifdef RB_ZERO_REG_EN
    assign wr_ok = bus.we && (bus.waddr != '0);
`else
    assign wr_ok = bus.we;
`endif

    assign run = (state_q == RUN);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        ar_d        = ar_q;
        br_d        = br_q;
        qa_d        = qa_q;
        qb_d        = qb_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = cnt_q;
        mem_wdata_d = '0;

        case (state_q)
            INIT: begin
                // Sweep zeroes one register per cycle; external writes are ignored.
                mem_we_d = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                mem_we_d    = wr_ok;
                mem_waddr_d = bus.waddr;
                mem_wdata_d = bus.wdata;
                if (!bus.stall) begin
                    qa_d = bus.addr_a;
                    qb_d = bus.addr_b;
                    ar_d = (wr_ok && (bus.waddr == bus.addr_a)) ? bus.wdata : mem_q[bus.addr_a];
                    br_d = (wr_ok && (bus.waddr == bus.addr_b)) ? bus.wdata : mem_q[bus.addr_b];
                end else begin
                    // Held operands still track writes to their captured register.
                    if (wr_ok && (bus.waddr == qa_q)) ar_d = bus.wdata;
                    if (wr_ok && (bus.waddr == qb_q)) br_d = bus.wdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            ar_q    <= '0;
            br_q    <= '0;
            qa_q    <= '0;
            qb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            ar_q    <= ar_d;
            br_q    <= br_d;
            qa_q    <= qa_d;
            qb_q    <= qb_d;
        end
    end

    // A write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_d) mem_q[mem_waddr_d] <= mem_wdata_d;
    end

    rb_fwd_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
        .qaddr   (qa_q),
        .v_ex    (bus.v_ex && run),
        .v_dm    (bus.v_dm && run),
        .v_wb    (bus.v_wb && run),
        .rd_ex   (bus.rd_ex),
        .rd_dm   (bus.rd_dm),
        .rd_wb   (bus.rd_wb),
        .ans_ex  (bus.ans_ex),
        .ans_dm  (bus.ans_dm),
        .ans_wb  (bus.ans_wb),
        .rf_data (ar_q),
        .data    (data_a),
        .sel     (sel_a)
    );

    rb_fwd_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
        .qaddr   (qb_q),
        .v_ex    (bus.v_ex && run),
        .v_dm    (bus.v_dm && run),
        .v_wb    (bus.v_wb && run),
        .rd_ex   (bus.rd_ex),
        .rd_dm   (bus.rd_dm),
        .rd_wb   (bus.rd_wb),
        .ans_ex  (bus.ans_ex),
        .ans_dm  (bus.ans_dm),
        .ans_wb  (bus.ans_wb),
        .rf_data (br_q),
        .data    (data_b),
        .sel     (sel_b)
    );

    assign bus.ready     = ready_q;
    assign bus.A         = data_a;
    assign bus.B         = bus.imm_sel ? bus.imm : data_b;
    assign bus.fwd_sel_a = sel_a;
    assign bus.fwd_sel_b = sel_b;

endmodule

// File: tb/tb_rb_block_fwd.sv
// Scoreboard bench for rb_block_fwd: directed scenarios plus random traffic
// against a behavioural register-bank model. Honours RB_ZERO_REG_EN.
module tb_rb_block_fwd;

    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

`ifdef RB_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rb_block_fwd_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    rb_block_fwd #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      nm;
        logic       rdy;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] sa;
        logic [1:0] sb;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [7:0] m_mem [DEPTH];
    bit         m_run   = 1'b0;
    int         m_sweep = 0;
    logic [7:0] m_ar    = 8'h00;
    logic [7:0] m_br    = 8'h00;
    int         m_qa    = 0;
    int         m_qb    = 0;

    function automatic void resolve(input int q, input logic [7:0] rf,
                                    output logic [7:0] d, output logic [1:0] s);
        logic [7:0] ans [3];
        bit         v   [3];
        int         rd  [3];
        bit         found;
        ans = '{bus.ans_ex, bus.ans_dm, bus.ans_wb};
        v   = '{bus.v_ex, bus.v_dm, bus.v_wb};
        rd  = '{int'(bus.rd_ex), int'(bus.rd_dm), int'(bus.rd_wb)};
        d = rf;
        s = 2'b00;
        found = 1'b0;
        if (!m_run || (ZR && q == 0)) return;
        for (int i = 0; i < 3; i++) begin
            if (!found && v[i] && rd[i] == q) begin
                d = ans[i];
                s = 2'(i + 1);
                found = 1'b1;
            end
        end
    endfunction

    function automatic exp_t predict(input string nm);
        exp_t       e;
        logic [7:0] bi;
        e.nm  = nm;
        e.rdy = m_run;
        resolve(m_qa, m_ar, e.a, e.sa);
        resolve(m_qb, m_br, bi, e.sb);
        e.b = bus.imm_sel ? bus.imm : bi;
        return e;
    endfunction

    function automatic void model_update();
        bit         wr;
        logic [7:0] nar, nbr;
        if (!rst_n) begin
            m_run = 1'b0; m_sweep = 0;
            m_ar = 8'h00; m_br = 8'h00; m_qa = 0; m_qb = 0;
            return;
        end
        if (!m_run) begin
            m_mem[m_sweep] = 8'h00;
            m_sweep++;
            if (m_sweep == DEPTH) m_run = 1'b1;
            return;
        end
        wr = bus.we && !(ZR && bus.waddr == 5'd0);
        if (bus.stall) begin
            nar = (wr && int'(bus.waddr) == m_qa) ? bus.wdata : m_ar;
            nbr = (wr && int'(bus.waddr) == m_qb) ? bus.wdata : m_br;
        end else begin
            nar = (wr && bus.waddr == bus.addr_a) ? bus.wdata : m_mem[bus.addr_a];
            nbr = (wr && bus.waddr == bus.addr_b) ? bus.wdata : m_mem[bus.addr_b];
            m_qa = int'(bus.addr_a);
            m_qb = int'(bus.addr_b);
        end
        if (wr) m_mem[bus.waddr] = bus.wdata;
        m_ar = nar;
        m_br = nbr;
    endfunction

    task automatic chk(input string nm, input string f, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s.%s got=%h exp=%h t=%0t", nm, f, got, exp, $time);
        end
    endtask

    // Monitor: compare at the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk(e.nm, "ready", {7'b0, bus.ready}, {7'b0, e.rdy});
            chk(e.nm, "A", bus.A, e.a);
            chk(e.nm, "B", bus.B, e.b);
            chk(e.nm, "sel_a", {6'b0, bus.fwd_sel_a}, {6'b0, e.sa});
            chk(e.nm, "sel_b", {6'b0, bus.fwd_sel_b}, {6'b0, e.sb});
        end
    end

    task automatic idle_inputs();
        bus.stall = 1'b0; bus.addr_a = 5'd0; bus.addr_b = 5'd0;
        bus.we = 1'b0; bus.waddr = 5'd0; bus.wdata = 8'h00;
        bus.ans_ex = 8'h00; bus.ans_dm = 8'h00; bus.ans_wb = 8'h00;
        bus.rd_ex = 5'd0; bus.rd_dm = 5'd0; bus.rd_wb = 5'd0;
        bus.v_ex = 1'b0; bus.v_dm = 1'b0; bus.v_wb = 1'b0;
        bus.imm = 8'h00; bus.imm_sel = 1'b0;
    endtask

    task automatic step(input string nm);
        sbq.push_back(predict(nm));
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        step("rst0");
        step("rst1");
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) step("sweep");

        for (int i = 0; i < DEPTH; i++) begin
            bus.addr_a = 5'(i);
            bus.addr_b = 5'(DEPTH - 1 - i);
            step("clr_rd");
        end
        step("clr_rd_last");

        // Write then read, and write-first bypass
        bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 8'hA7; step("wr5");
        bus.we = 1'b0; bus.addr_a = 5'd5; step("rd5");
        step("rd5_hold");
        bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 8'h3C; bus.addr_b = 5'd9; step("wf9");
        bus.we = 1'b0; step("wf9_rd");

        // Forward priority
        bus.addr_a = 5'd7; step("cap7");
        bus.v_ex = 1'b1; bus.v_dm = 1'b1; bus.v_wb = 1'b1;
        bus.rd_ex = 5'd7; bus.rd_dm = 5'd7; bus.rd_wb = 5'd7;
        bus.ans_ex = 8'h11; bus.ans_dm = 8'h22; bus.ans_wb = 8'h33;
        step("fwd_ex");
        bus.v_ex = 1'b0; step("fwd_dm");
        bus.v_dm = 1'b0; step("fwd_wb");
        bus.v_wb = 1'b0; step("fwd_none");

        // Stall hold with a write to the held register
        bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 8'h40; step("wr3");
        bus.we = 1'b0; bus.addr_a = 5'd3; step("cap3");
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.addr_a = 5'(10 + i);
            step("stall_hold");
        end
        bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 8'h41; step("stall_wr");
        bus.we = 1'b0; step("stall_upd");
        bus.stall = 1'b0; step("unstall");

        // Immediate over a forwarded B
        bus.addr_b = 5'd2; step("cap2");
        bus.imm_sel = 1'b1; bus.imm = 8'hFE;
        bus.v_ex = 1'b1; bus.rd_ex = 5'd2; bus.ans_ex = 8'h5A; step("imm");
        idle_inputs(); step("imm_off");

        // Register 0 handling
        bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 8'h55; bus.addr_a = 5'd0; step("wr0");
        bus.we = 1'b0; bus.v_ex = 1'b1; bus.rd_ex = 5'd0; bus.ans_ex = 8'h99; step("zero_fwd");
        bus.v_ex = 1'b0; step("zero_rf");
        idle_inputs();

        // Random traffic, including occasional mid-run reset
        for (int n = 0; n < 800; n++) begin
            rst_n        = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
            bus.stall    = ($urandom_range(0, 3) == 0);
            bus.addr_a   = rnd_addr();
            bus.addr_b   = rnd_addr();
            bus.we       = ($urandom_range(0, 1) == 1);
            bus.waddr    = rnd_addr();
            bus.wdata    = 8'($urandom);
            bus.ans_ex   = 8'($urandom);
            bus.ans_dm   = 8'($urandom);
            bus.ans_wb   = 8'($urandom);
            bus.rd_ex    = rnd_addr();
            bus.rd_dm    = rnd_addr();
            bus.rd_wb    = rnd_addr();
            bus.v_ex     = ($urandom_range(0, 2) == 0);
            bus.v_dm     = ($urandom_range(0, 2) == 0);
            bus.v_wb     = ($urandom_range(0, 2) == 0);
            bus.imm      = 8'($urandom);
            bus.imm_sel  = ($urandom_range(0, 4) == 0);
            step("rand");
        end
        rst_n = 1'b1;
        idle_inputs();

        for (int i = 0; i < 4 && sbq.size() != 0; i++) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
